// File: rtl/rr_burst_arbiter_if.sv
// Request/grant bus between the request sources, the shared target and
// the round-robin burst arbiter. The master side drives requests and
// acknowledges; the slave side (the arbiter) drives the grant signals.
interface rr_burst_arbiter_if #(
    parameter int N   = 4,
    parameter int IDW = $clog2(N)
);
    logic [N-1:0]   req;
    logic           ack;
    logic [N-1:0]   grant;
    logic [IDW-1:0] grant_id;
    logic           busy;
    logic           timeout;

    modport master (
        output req,
        output ack,
        input  grant,
        input  grant_id,
        input  busy,
        input  timeout
    );

    modport slave (
        input  req,
        input  ack,
        output grant,
        output grant_id,
        output busy,
        output timeout
    );
endinterface

// File: rtl/rr_burst_arbiter.sv
// Round-robin arbiter for N requesters sharing one target. The winner
// keeps a registered one-hot grant until the target acks; it may chain up
// to MAX_BURST transactions while it keeps requesting. A watchdog releases
// a grant that sees no ack for TIMEOUT cycles (TIMEOUT = 0 disables it).
// After every release the search pointer moves to the requester just
// after the previous owner.
module rr_burst_arbiter #(
    parameter int N         = 4,
    parameter int MAX_BURST = 1,
    parameter int TIMEOUT   = 16,
    parameter int IDW       = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst,
    rr_burst_arbiter_if.slave  bus
);

    localparam int BW = $clog2(MAX_BURST) + 1;
    localparam int WW = $clog2(TIMEOUT) + 1;
    localparam logic [BW-1:0]  BURST_LAST = BW'(MAX_BURST - 1);
    localparam logic [WW-1:0]  WAIT_LAST  = WW'(TIMEOUT - 1);
    localparam bit             WDOG_EN    = (TIMEOUT != 32'sd0);
    localparam logic [IDW-1:0] LAST_ID    = IDW'(N - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t         state_r, state_s;
    logic [N-1:0]   grant_r, grant_s;
    logic [IDW-1:0] grant_id_r, grant_id_s;
    logic           busy_r, busy_s;
    logic           timeout_r, timeout_s;
    logic [IDW-1:0] ptr_r, ptr_s;
    logic [IDW-1:0] owner_r, owner_s;
    logic [BW-1:0]  burst_cnt_r, burst_cnt_s;
    logic [WW-1:0]  wait_cnt_r, wait_cnt_s;
    logic           found_s;
    logic [IDW-1:0] win_s;

    // Pointer after a release: explicit wrap so non-power-of-two N works
    function automatic logic [IDW-1:0] next_ptr(input logic [IDW-1:0] id);
        if (id == LAST_ID) begin
            return {IDW{1'b0}};
        end else begin
            return id + IDW'(1);
        end
    endfunction

    // One-hot decode of a requester index
    function automatic logic [N-1:0] onehot(input logic [IDW-1:0] id);
        logic [N-1:0] v;
        v     = {N{1'b0}};
        v[id] = 1'b1;
        return v;
    endfunction

    // Rotating-priority scan: first active requester at or after ptr wins
    always_comb begin : arb_scan
        int c;
        found_s = 1'b0;
        win_s   = {IDW{1'b0}};
        c       = 0;
        for (int i = 0; i < N; i++) begin
            c = (int'(ptr_r) + i) % N;
            if (!found_s && bus.req[c]) begin
                found_s = 1'b1;
                win_s   = IDW'(c);
            end else begin
                found_s = found_s;
            end
        end
    end

    // Next-state and next-output logic for the IDLE/GRANT controller
    always_comb begin
        state_s     = state_r;
        grant_s     = grant_r;
        grant_id_s  = grant_id_r;
        busy_s      = busy_r;
        timeout_s   = 1'b0;
        ptr_s       = ptr_r;
        owner_s     = owner_r;
        burst_cnt_s = burst_cnt_r;
        wait_cnt_s  = wait_cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (found_s) begin
                    state_s     = ST_GRANT;
                    grant_s     = onehot(win_s);
                    grant_id_s  = win_s;
                    busy_s      = 1'b1;
                    owner_s     = win_s;
                    burst_cnt_s = {BW{1'b0}};
                    wait_cnt_s  = {WW{1'b0}};
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_GRANT: begin
                if (bus.ack) begin
                    // ack beats the watchdog when both land in the same cycle
                    if (bus.req[owner_r] && (burst_cnt_r < BURST_LAST)) begin
                        burst_cnt_s = burst_cnt_r + BW'(1);
                        wait_cnt_s  = {WW{1'b0}};
                    end else begin
                        state_s    = ST_IDLE;
                        grant_s    = {N{1'b0}};
                        grant_id_s = {IDW{1'b0}};
                        busy_s     = 1'b0;
                        ptr_s      = next_ptr(owner_r);
                    end
                end else if (WDOG_EN && (wait_cnt_r == WAIT_LAST)) begin
                    state_s    = ST_IDLE;
                    grant_s    = {N{1'b0}};
                    grant_id_s = {IDW{1'b0}};
                    busy_s     = 1'b0;
                    timeout_s  = 1'b1;
                    ptr_s      = next_ptr(owner_r);
                end else if (WDOG_EN) begin
                    wait_cnt_s = wait_cnt_r + WW'(1);
                end else begin
                    // watchdog disabled: hold the counter so it never wraps
                    wait_cnt_s = {WW{1'b0}};
                end
            end
            default: begin
                state_s    = ST_IDLE;
                grant_s    = {N{1'b0}};
                grant_id_s = {IDW{1'b0}};
                busy_s     = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            grant_r     <= {N{1'b0}};
            grant_id_r  <= {IDW{1'b0}};
            busy_r      <= 1'b0;
            timeout_r   <= 1'b0;
            ptr_r       <= {IDW{1'b0}};
            owner_r     <= {IDW{1'b0}};
            burst_cnt_r <= {BW{1'b0}};
            wait_cnt_r  <= {WW{1'b0}};
        end else begin
            state_r     <= state_s;
            grant_r     <= grant_s;
            grant_id_r  <= grant_id_s;
            busy_r      <= busy_s;
            timeout_r   <= timeout_s;
            ptr_r       <= ptr_s;
            owner_r     <= owner_s;
            burst_cnt_r <= burst_cnt_s;
            wait_cnt_r  <= wait_cnt_s;
        end
    end

    assign bus.grant    = grant_r;
    assign bus.grant_id = grant_id_r;
    assign bus.busy     = busy_r;
    assign bus.timeout  = timeout_r;

endmodule

// File: tb/tb_rr_burst_arbiter.sv
// Testbench for rr_burst_arbiter: two instances (N=4/MAX_BURST=2/TIMEOUT=8
// and N=3/MAX_BURST=1/TIMEOUT=5). A reference model predicts the outputs
// after every rising edge and queues them; monitors compare on the falling
// edge. Directed scenarios are followed by a long randomized run.
module tb_rr_burst_arbiter;

    localparam int N0 = 4, MB0 = 2, TO0 = 8;
    localparam int N1 = 3, MB1 = 1, TO1 = 5;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rr_burst_arbiter_if #(.N(N0)) bus0 ();
    rr_burst_arbiter_if #(.N(N1)) bus1 ();

    rr_burst_arbiter #(.N(N0), .MAX_BURST(MB0), .TIMEOUT(TO0)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0.slave)
    );

    rr_burst_arbiter #(.N(N1), .MAX_BURST(MB1), .TIMEOUT(TO1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1.slave)
    );

    typedef struct {
        logic [31:0] grant;
        int          id;
        bit          busy;
        bit          to;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t e0, e1;

    int cfg_n[2]  = '{N0, N1};
    int cfg_mb[2] = '{MB0, MB1};
    int cfg_to[2] = '{TO0, TO1};

    // model state: owner (-1 = nobody), pointer, acks seen in tenure, cycles waited
    int m_owner[2] = '{-1, -1};
    int m_ptr[2]   = '{0, 0};
    int m_txn[2]   = '{0, 0};
    int m_wait[2]  = '{0, 0};

    int n_checks = 0;
    int n_fail   = 0;
    int ack0_mode, ack1_mode;   // 0 none, 1 whenever granted, 2 random, 3 manual

    logic [3:0] rot0 [13] = '{4'h1, 4'h1, 4'h0, 4'h2, 4'h2, 4'h0, 4'h4, 4'h4,
                              4'h0, 4'h8, 4'h8, 4'h0, 4'h1};
    logic [2:0] rot1 [7]  = '{3'h1, 3'h0, 3'h2, 3'h0, 3'h4, 3'h0, 3'h1};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference behaviour for one rising edge; returns the outputs expected after it
    function automatic exp_t model_step(int k, logic [31:0] r, logic a, logic rs);
        exp_t e;
        int   n;
        n    = cfg_n[k];
        e.to = 1'b0;
        if (rs) begin
            m_owner[k] = -1;
            m_ptr[k]   = 0;
            m_txn[k]   = 0;
            m_wait[k]  = 0;
        end else if (m_owner[k] < 0) begin
            for (int i = 0; i < n; i++) begin
                int c;
                c = (m_ptr[k] + i) % n;
                if (m_owner[k] < 0 && r[c] === 1'b1) m_owner[k] = c;
            end
            m_txn[k]  = 0;
            m_wait[k] = 0;
        end else if (a === 1'b1) begin
            m_txn[k]++;
            if (r[m_owner[k]] === 1'b1 && m_txn[k] < cfg_mb[k]) begin
                m_wait[k] = 0;
            end else begin
                m_ptr[k]   = (m_owner[k] + 1) % n;
                m_owner[k] = -1;
            end
        end else begin
            m_wait[k]++;
            if (cfg_to[k] != 0 && m_wait[k] == cfg_to[k]) begin
                m_ptr[k]   = (m_owner[k] + 1) % n;
                m_owner[k] = -1;
                e.to       = 1'b1;
            end
        end
        e.grant = (m_owner[k] < 0) ? 32'd0 : (32'd1 << m_owner[k]);
        e.id    = (m_owner[k] < 0) ? 0 : m_owner[k];
        e.busy  = (m_owner[k] >= 0);
        return e;
    endfunction

    // Stimulus side of the scoreboard: predict on every rising edge
    initial begin
        forever begin
            @(posedge clk);
            q0.push_back(model_step(0, 32'(bus0.req), bus0.ack, rst));
            q1.push_back(model_step(1, 32'(bus1.req), bus1.ack, rst));
        end
    end

    // Monitor for instance 0
    initial begin
        forever begin
            @(negedge clk);
            if (q0.size() > 0) begin
                e0 = q0.pop_front();
                check("i0 grant",    32'(bus0.grant),    e0.grant);
                check("i0 grant_id", 32'(bus0.grant_id), 32'(e0.id));
                check("i0 busy",     32'(bus0.busy),     32'(e0.busy));
                check("i0 timeout",  32'(bus0.timeout),  32'(e0.to));
            end
        end
    end

    // Monitor for instance 1
    initial begin
        forever begin
            @(negedge clk);
            if (q1.size() > 0) begin
                e1 = q1.pop_front();
                check("i1 grant",    32'(bus1.grant),    e1.grant);
                check("i1 grant_id", 32'(bus1.grant_id), 32'(e1.id));
                check("i1 busy",     32'(bus1.busy),     32'(e1.busy));
                check("i1 timeout",  32'(bus1.timeout),  32'(e1.to));
            end
        end
    end

    task automatic set_req(input logic [3:0] r);
        bus0.req = r;
        bus1.req = r[2:0];
    endtask

    // Advance to the next falling edge and drive the target acks
    task automatic tick();
        @(negedge clk);
        case (ack0_mode)
            0:       bus0.ack = 1'b0;
            1:       bus0.ack = |bus0.grant;
            2:       bus0.ack = ($urandom_range(0, 2) == 0);
            default: bus0.ack = bus0.ack;
        endcase
        case (ack1_mode)
            0:       bus1.ack = 1'b0;
            1:       bus1.ack = |bus1.grant;
            2:       bus1.ack = ($urandom_range(0, 2) == 0);
            default: bus1.ack = 1'b0;
        endcase
    endtask

    initial begin
        int  cnt;
        bit  seen;
        bit  done;

        rst       = 1'b1;
        set_req(4'b0000);
        bus0.ack  = 1'b0;
        bus1.ack  = 1'b0;
        ack0_mode = 0;
        ack1_mode = 0;

        // reset state
        tick();
        tick();
        check("reset grant",    32'(bus0.grant),    32'd0);
        check("reset grant_id", 32'(bus0.grant_id), 32'd0);
        check("reset busy",     32'(bus0.busy),     32'd0);
        check("reset timeout",  32'(bus0.timeout),  32'd0);

        // 1. rotation with all requesters active
        rst = 1'b0;
        set_req(4'b1111);
        ack0_mode = 1;
        ack1_mode = 1;
        for (int i = 0; i < 13; i++) begin
            tick();
            check($sformatf("rotation i0 cycle %0d", i), 32'(bus0.grant), 32'(rot0[i]));
            if (i < 7) check($sformatf("rotation i1 cycle %0d", i), 32'(bus1.grant), 32'(rot1[i]));
        end

        // 2. lone requester keeps winning as the pointer passes it
        set_req(4'b0100);
        for (int i = 0; i < 12; i++) begin
            tick();
            check("lone requester only", 32'(bus0.grant & 4'b1011), 32'd0);
        end

        // 3. watchdog with no ack
        rst = 1'b1;
        ack0_mode = 3;
        bus0.ack  = 1'b0;
        ack1_mode = 2;
        tick();
        rst = 1'b0;
        set_req(4'b0010);
        cnt  = 0;
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            tick();
            if (bus0.timeout) seen = 1'b1;
            else if (bus0.grant == 4'b0010) cnt++;
        end
        check("watchdog pulse seen", 32'(seen), 32'd1);
        check("watchdog grant cycles", 32'(cnt), 32'(TO0));
        check("watchdog grant low with pulse", 32'(bus0.grant), 32'd0);
        tick();
        check("regrant after watchdog", 32'(bus0.grant), 32'(4'b0010));

        // 4. ack in the final watchdog cycle continues the burst
        rst = 1'b1;
        tick();
        rst = 1'b0;
        set_req(4'b0010);
        cnt  = 0;
        seen = 1'b0;
        done = 1'b0;
        for (int i = 0; i < 30 && !done; i++) begin
            tick();
            bus0.ack = 1'b0;
            if (bus0.timeout) seen = 1'b1;
            if (bus0.grant == 4'b0010) begin
                cnt++;
                if (cnt == TO0) begin
                    bus0.ack = 1'b1;
                    done     = 1'b1;
                end
            end
        end
        check("late ack reached final cycle", 32'(done), 32'd1);
        tick();
        bus0.ack = 1'b0;
        check("late ack no timeout before", 32'(seen), 32'd0);
        check("late ack no timeout pulse", 32'(bus0.timeout), 32'd0);
        check("late ack grant held", 32'(bus0.grant), 32'(4'b0010));

        // 5. ack while idle is ignored; withdrawal ends grant only at ack
        rst = 1'b1;
        tick();
        rst = 1'b0;
        set_req(4'b0000);
        bus0.ack = 1'b1;
        tick();
        tick();
        check("idle ack grant", 32'(bus0.grant), 32'd0);
        check("idle ack busy", 32'(bus0.busy), 32'd0);
        bus0.ack = 1'b0;
        set_req(4'b0010);
        done = 1'b0;
        for (int i = 0; i < 5 && !done; i++) begin
            tick();
            if (bus0.grant != 4'b0000) done = 1'b1;
        end
        check("withdraw first grant", 32'(bus0.grant), 32'(4'b0010));
        set_req(4'b0000);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("withdraw grant held", 32'(bus0.grant), 32'(4'b0010));
        end
        bus0.ack = 1'b1;
        tick();
        bus0.ack = 1'b0;
        check("withdraw released", 32'(bus0.grant), 32'd0);
        set_req(4'b1001);
        tick();
        check("next winner from ptr 2", 32'(bus0.grant), 32'(4'b1000));

        // 6. reset mid-tenure restarts the pointer at 0
        ack0_mode = 1;
        ack1_mode = 1;
        set_req(4'b1111);
        done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            tick();
            if (bus0.grant == 4'b0100) done = 1'b1;
        end
        check("reached grant 0100", 32'(done), 32'd1);
        rst = 1'b1;
        tick();
        check("mid-tenure reset grant", 32'(bus0.grant), 32'd0);
        check("mid-tenure reset busy",  32'(bus0.busy),  32'd0);
        rst = 1'b0;
        for (int i = 0; i < 7; i++) begin
            tick();
            check($sformatf("post-reset i0 cycle %0d", i), 32'(bus0.grant), 32'(rot0[i]));
            check($sformatf("post-reset wrap i1 cycle %0d", i), 32'(bus1.grant), 32'(rot1[i]));
        end

        // 7. randomized traffic, acks and occasional resets
        ack0_mode = 2;
        ack1_mode = 2;
        for (int i = 0; i < 3000; i++) begin
            tick();
            rst = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 3) == 0) begin
                bus0.req = 4'($urandom);
                bus1.req = 3'($urandom);
            end
        end
        rst = 1'b0;
        tick();
        tick();

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

    // Absolute time bound so the bench can never hang
    initial begin
        #2000000;
        $display("FAIL global time limit: got expired, expected completion");
        $fatal(1);
    end

endmodule
